// File: rtl/clause_scheduler.sv
// Time-multiplexed clause scheduler: one latched 2-feature sample is fed through a shared clause
// evaluator, one clause per cycle, and the alternating-polarity votes are summed into a class score.
module clause_scheduler #(
    parameter int unsigned NUM_CLAUSES       = 8,
    parameter bit          EMPTY_CLAUSE_ZERO = 1'b1,
    localparam int unsigned CW               = $clog2(NUM_CLAUSES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_addr,
    input  logic [3:0]           cfg_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           features,
    output logic [1:0]           clause_features,
    output logic [3:0]           clause_exclude,
    input  logic                 clause_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [CW+1:0] class_sum,
    output logic                 prediction,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

    localparam logic signed [CW+1:0] SumOne  = 1;
    localparam logic signed [CW+1:0] SumZero = 0;
    localparam logic [CW-1:0]        IdxLast = CW'(NUM_CLAUSES - 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          idx_q, idx_d;
    logic signed [CW+1:0]   sum_q, sum_d;
    logic [1:0]             feat_q, feat_d;
    logic [3:0]             mask_q [NUM_CLAUSES];
    logic [3:0]             cur_mask;
    logic                   eff_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            sum_q   <= '0;
            feat_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            feat_q  <= feat_d;
        end
    end

    // Table writes are only taken while idle so an in-flight sample sees a consistent table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLAUSES; i++) begin
                mask_q[i] <= 4'b1111;
            end
        end else if (cfg_we && state_q == StIdle && (32'(cfg_addr) < NUM_CLAUSES)) begin
            mask_q[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        cur_mask   = mask_q[idx_q];
        eff_result = clause_result;
        if (EMPTY_CLAUSE_ZERO && cur_mask == 4'b1111) begin
            eff_result = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        feat_d  = feat_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    feat_d  = features;
                    sum_d   = '0;
                    idx_d   = '0;
                    state_d = StEval;
                end
            end
            StEval: begin
                // Even clauses vote for the class, odd clauses against it.
                if (eff_result) begin
                    sum_d = idx_q[0] ? (sum_q - SumOne) : (sum_q + SumOne);
                end
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready        = (state_q == StIdle);
        out_valid       = (state_q == StDone);
        busy            = (state_q == StEval) || (state_q == StDone);
        clause_features = feat_q;
        clause_exclude  = (state_q == StEval) ? cur_mask : 4'b1111;
        class_sum       = sum_q;
        prediction      = (sum_q > SumZero);
    end

endmodule

// File: tb/tb_clause_scheduler.sv
// Bench for clause_scheduler: two instances (empty clause counted as 0 / as 1) share stimulus and
// are compared against a clause-by-clause vote model.
module tb_clause_scheduler;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [2:0]        cfg_addr;
    logic [3:0]        cfg_data;
    logic              in_valid;
    logic              in_ready, in_ready_nz;
    logic [1:0]        features;
    logic [1:0]        clause_features, clause_features_nz;
    logic [3:0]        clause_exclude, clause_exclude_nz;
    logic              clause_result, clause_result_nz;
    logic              out_valid, out_valid_nz;
    logic              out_ready;
    logic signed [4:0] class_sum, class_sum_nz;
    logic              prediction, prediction_nz;
    logic              busy, busy_nz;

    int                n_checks = 0;
    int                n_pass   = 0;
    int                cyc      = 0;
    logic [3:0]        ref_mask [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Evaluator: AND of all literals not excluded by the mask.
    assign clause_result = &({clause_features[1], clause_features[0],
                              ~clause_features[1], ~clause_features[0]} | clause_exclude);
    assign clause_result_nz = &({clause_features_nz[1], clause_features_nz[0],
                                 ~clause_features_nz[1], ~clause_features_nz[0]} | clause_exclude_nz);

    clause_scheduler #(.NUM_CLAUSES(8), .EMPTY_CLAUSE_ZERO(1'b1)) u_dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .features        (features),
        .clause_features (clause_features),
        .clause_exclude  (clause_exclude),
        .clause_result   (clause_result),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .class_sum       (class_sum),
        .prediction      (prediction),
        .busy            (busy)
    );

    clause_scheduler #(.NUM_CLAUSES(8), .EMPTY_CLAUSE_ZERO(1'b0)) u_dut_nz (
        .clk             (clk),
        .rst             (rst),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready_nz),
        .features        (features),
        .clause_features (clause_features_nz),
        .clause_exclude  (clause_exclude_nz),
        .clause_result   (clause_result_nz),
        .out_valid       (out_valid_nz),
        .out_ready       (out_ready),
        .class_sum       (class_sum_nz),
        .prediction      (prediction_nz),
        .busy            (busy_nz)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int ref_sum(input logic [1:0] f, input bit empty_zero);
        int         s = 0;
        logic [3:0] lits;
        bit         r;
        lits = {f[1], f[0], ~f[1], ~f[0]};
        for (int k = 0; k < 8; k++) begin
            r = &(lits | ref_mask[k]);
            if (empty_zero && ref_mask[k] == 4'b1111) r = 1'b0;
            if (r) s += (k % 2 == 0) ? 1 : -1;
        end
        return s;
    endfunction

    task automatic cfg_write(input logic [2:0] a, input logic [3:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
        ref_mask[a] = d;
    endtask

    // Called at a negedge with the DUT idle; optionally writes the table in the accept cycle,
    // attempts a dropped write during evaluation, and stalls the result for `hold` cycles.
    task automatic run_sample(input logic [1:0] f, input int hold, input bit wr_en,
                              input logic [2:0] wr_addr, input logic [3:0] wr_data,
                              input bit eval_wr);
        int c0, es, es_nz;
        bit got;
        check("in_ready_idle", int'(in_ready), 1);
        in_valid = 1'b1; features = f;
        cfg_we = wr_en; cfg_addr = wr_addr; cfg_data = wr_data;
        c0 = cyc;
        @(negedge clk);
        in_valid = 1'b0; cfg_we = 1'b0;
        if (wr_en) ref_mask[wr_addr] = wr_data;
        es    = ref_sum(f, 1'b1);
        es_nz = ref_sum(f, 1'b0);
        check("busy_eval", int'(busy), 1);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1;
            end else begin
                if (eval_wr && i == 2) begin
                    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 4'b1011;
                end else begin
                    cfg_we = 1'b0;
                end
                @(negedge clk);
            end
        end
        cfg_we = 1'b0;
        check("result_seen", int'(got), 1);
        check("latency", cyc - c0, 9);
        check("class_sum", int'(class_sum), es);
        check("prediction", int'(prediction), int'(es > 0));
        check("class_sum_nz", int'(class_sum_nz), es_nz);
        check("clause_features", int'(clause_features), int'(f));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; features = ~f;
            @(negedge clk);
            check("hold_valid", int'(out_valid), 1);
            check("hold_sum", int'(class_sum), es);
            check("hold_in_ready", int'(in_ready), 0);
            check("hold_exclude", int'(clause_exclude), 15);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_busy", int'(busy), 0);
        check("idle_features_held", int'(clause_features), int'(f));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seen;
        int          acc;
        bit          hs;
        int          t_q[$];
        int          s_q[$];
        logic [1:0]  fs;

        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; features = '0; out_ready = 1'b0;
        for (int k = 0; k < 8; k++) ref_mask[k] = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_sum", int'(class_sum), 0);
        check("rst_pred", int'(prediction), 0);
        check("rst_features", int'(clause_features), 0);
        check("rst_exclude", int'(clause_exclude), 15);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);

        // Unconfigured table: both variants must score zero.
        run_sample(2'b10, 0, 1'b0, 3'd0, 4'd0, 1'b0);
        check("empty_zero", int'(class_sum_nz), 0);

        // Default table; the last write rides along with the first accepted sample.
        cfg_write(3'd0, 4'b1001);
        cfg_write(3'd1, 4'b0011);
        cfg_write(3'd2, 4'b0110);
        run_sample(2'b01, 0, 1'b1, 3'd3, 4'b1100, 1'b0);
        check("s1_sum", int'(class_sum), 1);
        run_sample(2'b10, 1, 1'b0, 3'd0, 4'd0, 1'b0);
        run_sample(2'b11, 0, 1'b0, 3'd0, 4'd0, 1'b0);
        run_sample(2'b00, 2, 1'b0, 3'd0, 4'd0, 1'b0);

        // Stalled result with ignored input and a dropped mid-evaluation write.
        run_sample(2'b11, 5, 1'b0, 3'd0, 4'd0, 1'b1);
        run_sample(2'b01, 0, 1'b0, 3'd0, 4'd0, 1'b0);
        check("eval_write_dropped", int'(class_sum), 1);

        // Back-to-back samples with out_ready held high.
        out_ready = 1'b1; in_valid = 1'b1; features = 2'b01; acc = 0;
        for (int i = 0; i < 40; i++) begin
            hs = in_valid && in_ready;
            if (out_valid) begin
                t_q.push_back(cyc);
                s_q.push_back(int'(class_sum));
            end
            @(negedge clk);
            if (hs) begin
                acc++;
                if (acc == 1) features = 2'b11;
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        check("b2b_count", t_q.size(), 2);
        if (t_q.size() == 2) begin
            check("b2b_first", s_q[0], ref_sum(2'b01, 1'b1));
            check("b2b_second", s_q[1], ref_sum(2'b11, 1'b1));
            check("b2b_spacing", t_q[1] - t_q[0], 10);
        end

        // Reset in the middle of evaluation (clause index 3).
        in_valid = 1'b1; features = 2'b01;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_sum", int'(class_sum), 0);
        check("mid_rst_exclude", int'(clause_exclude), 15);
        check("mid_rst_features", int'(clause_features), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) ref_mask[k] = 4'b1111;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        check("mid_rst_no_result", seen, 0);
        run_sample(2'b01, 0, 1'b0, 3'd0, 4'd0, 1'b0);
        check("mid_rst_masks", int'(class_sum), 0);

        // Random tables and samples against the vote model.
        for (int n = 0; n < 16; n++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            fs = 2'($urandom_range(0, 3));
            run_sample(fs, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
